// File: rtl/eth_rx_demux.sv
// eth_rx_demux: Ethernet RX parser and router. Matches dest MAC and EtherType, decodes the
//   16-bit user header and steers COMMAND frames to the cmd port and DATA payload to channel m_tdest.
// Latency: payload byte accept -> m_tvalid is 1 cycle; cmd/err strobes appear the cycle after the deciding byte.
// Backpressure: s_tready drops only in PAY while the one-entry output register is held (m_tvalid && !m_tready).
// Ports: clk/reset (async, active-high); mac_addr (byte 0 = [47:40]); s_* AXI-S byte input;
//   m_* payload output with m_tfirst/m_tlast/m_tdest; len_out declared length; cmd_valid/cmd_code;
//   err_valid/err_code (1 RUNT, 2 HDR_BAD, 3 CH_BAD, 4 LEN_BAD, 5 LEN_SHORT, 6 LEN_LONG, 7 TIMEOUT).
// Optional: define ETH_RX_BCAST_EN to also accept destination FF:FF:FF:FF:FF:FF.
module eth_rx_demux #(
    parameter int          NUM_CH         = 4,
    parameter logic [15:0] ETHERTYPE      = 16'h0800,
    parameter int          MAX_LEN        = 1500,
    parameter int          TIMEOUT_CYCLES = 1023,
    localparam int         DW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [47:0]   mac_addr,
    input  logic [7:0]    s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [7:0]    m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          m_tfirst,
    output logic [DW-1:0] m_tdest,
    output logic [15:0]   len_out,
    output logic          cmd_valid,
    output logic [3:0]    cmd_code,
    output logic          err_valid,
    output logic [2:0]    err_code
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] E_RUNT      = 3'd1;
    localparam logic [2:0] E_HDR_BAD   = 3'd2;
    localparam logic [2:0] E_CH_BAD    = 3'd3;
    localparam logic [2:0] E_LEN_BAD   = 3'd4;
    localparam logic [2:0] E_LEN_SHORT = 3'd5;
    localparam logic [2:0] E_LEN_LONG  = 3'd6;
    localparam logic [2:0] E_TIMEOUT   = 3'd7;

    typedef enum logic [2:0] {ST_DST, ST_SRC, ST_TYPE, ST_HDR, ST_LEN, ST_PAY, ST_DROP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;        // byte index within the current field / payload
    logic [7:0]      fld_q, fld_d;        // first byte of a 2-byte field
    logic            match_q, match_d;    // dest MAC matched so far
`ifdef ETH_RX_BCAST_EN
    logic            bc_q, bc_d;          // dest MAC all-ones so far
`endif
    logic [DW-1:0]   ch_q, ch_d;
    logic [15:0]     len_q, len_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            err_seen_q, err_seen_d; // an error was already reported for this frame
    logic [7:0]      m_tdata_q, m_tdata_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q, m_tlast_d;
    logic            m_tfirst_q, m_tfirst_d;
    logic [DW-1:0]   m_tdest_q, m_tdest_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [3:0]      cmd_code_q, cmd_code_d;
    logic            err_valid_q, err_valid_d;
    logic [2:0]      err_code_q, err_code_d;

    logic            acc, timing, tmo_hit, ev_err, dst_ok, last_hit;
    logic [2:0]      ev_code;
    logic [7:0]      mac_byte;
    logic [15:0]     word;

    assign s_tready = !reset && ((state_q != ST_PAY) || !m_tvalid_q || m_tready);
    assign acc      = s_tvalid && s_tready;
    // The idle timer runs everywhere except while waiting for the first byte of a frame.
    assign timing   = (state_q != ST_DST) || (cnt_q != 16'd0);
    assign tmo_hit  = timing && !s_tvalid && (idle_q == TW'(TIMEOUT_CYCLES - 1));
    assign word     = {fld_q, s_tdata};
    assign last_hit = (cnt_q + 16'd1) == len_q;

    always_comb begin
        case (cnt_q[2:0])
            3'd0:    mac_byte = mac_addr[47:40];
            3'd1:    mac_byte = mac_addr[39:32];
            3'd2:    mac_byte = mac_addr[31:24];
            3'd3:    mac_byte = mac_addr[23:16];
            3'd4:    mac_byte = mac_addr[15:8];
            default: mac_byte = mac_addr[7:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fld_d       = fld_q;
        match_d     = match_q;
`ifdef ETH_RX_BCAST_EN
        bc_d        = bc_q;
`endif
        ch_d        = ch_q;
        len_d       = len_q;
        idle_d      = idle_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tfirst_d  = m_tfirst_q;
        m_tdest_d   = m_tdest_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        ev_err      = 1'b0;
        ev_code     = 3'd0;
        dst_ok      = 1'b0;

        if (m_tvalid_q && m_tready) m_tvalid_d = 1'b0;

        if (acc)                    idle_d = '0;
        else if (!s_tvalid && timing) idle_d = idle_q + 1'b1;

        if (acc) begin
            case (state_q)
                ST_DST: begin
                    match_d = ((cnt_q == 16'd0) || match_q) && (s_tdata == mac_byte);
`ifdef ETH_RX_BCAST_EN
                    bc_d    = ((cnt_q == 16'd0) || bc_q) && (s_tdata == 8'hFF);
                    dst_ok  = match_d || bc_d;
`else
                    dst_ok  = match_d;
`endif
                    if (s_tlast) begin
                        ev_err = 1'b1; ev_code = E_RUNT; cnt_d = '0;
                    end else if (cnt_q == 16'd5) begin
                        cnt_d   = '0;
                        state_d = dst_ok ? ST_SRC : ST_DROP;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_SRC: begin
                    if (s_tlast) begin
                        ev_err = 1'b1; ev_code = E_RUNT; state_d = ST_DST; cnt_d = '0;
                    end else if (cnt_q == 16'd5) begin
                        state_d = ST_TYPE; cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_TYPE, ST_HDR, ST_LEN: begin
                    cnt_d = '0;
                    if (s_tlast) begin
                        ev_err = 1'b1; ev_code = E_RUNT; state_d = ST_DST;
                    end else if (cnt_q == 16'd0) begin
                        fld_d = s_tdata;
                        cnt_d = 16'd1;
                    end else if (state_q == ST_TYPE) begin
                        state_d = (word == ETHERTYPE) ? ST_HDR : ST_DROP;
                    end else if (state_q == ST_HDR) begin
                        state_d = ST_DROP;
                        if (fld_q[7:6] == 2'b10) begin
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = fld_q[3:0];
                        end else if (fld_q[7:6] != 2'b01) begin
                            ev_err = 1'b1; ev_code = E_HDR_BAD;
                        end else if ({1'b0, fld_q[3:0]} >= 5'(NUM_CH)) begin
                            ev_err = 1'b1; ev_code = E_CH_BAD;
                        end else begin
                            ch_d    = fld_q[DW-1:0];
                            state_d = ST_LEN;
                        end
                    end else begin
                        len_d = word;
                        if (word == 16'd0 || word > 16'(MAX_LEN)) begin
                            ev_err = 1'b1; ev_code = E_LEN_BAD; state_d = ST_DROP;
                        end else begin
                            state_d = ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    // s_tready guarantees the output register is free or being drained now.
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = s_tdata;
                    m_tfirst_d = (cnt_q == 16'd0);
                    m_tdest_d  = ch_q;
                    m_tlast_d  = s_tlast || last_hit;
                    cnt_d      = cnt_q + 16'd1;
                    if (s_tlast) begin
                        state_d = ST_DST; cnt_d = '0;
                        if (!last_hit) begin ev_err = 1'b1; ev_code = E_LEN_SHORT; end
                    end else if (last_hit) begin
                        state_d = ST_DROP; cnt_d = '0;
                        ev_err = 1'b1; ev_code = E_LEN_LONG;
                    end
                end
                default: begin // ST_DROP
                    if (s_tlast) begin state_d = ST_DST; cnt_d = '0; end
                end
            endcase
        end

        // Timeout abandons the frame; a beat already in the output register still drains.
        if (tmo_hit) begin
            ev_err = 1'b1; ev_code = E_TIMEOUT;
            state_d = ST_DST; cnt_d = '0; idle_d = '0;
        end

        if (ev_err && !err_seen_q) begin
            err_valid_d = 1'b1;
            err_code_d  = ev_code;
        end
        err_seen_d = (state_d != ST_DST) && (err_seen_q || ev_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_DST;
            cnt_q       <= '0;
            fld_q       <= '0;
            match_q     <= 1'b0;
`ifdef ETH_RX_BCAST_EN
            bc_q        <= 1'b0;
`endif
            ch_q        <= '0;
            len_q       <= '0;
            idle_q      <= '0;
            err_seen_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tfirst_q  <= 1'b0;
            m_tdest_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fld_q       <= fld_d;
            match_q     <= match_d;
`ifdef ETH_RX_BCAST_EN
            bc_q        <= bc_d;
`endif
            ch_q        <= ch_d;
            len_q       <= len_d;
            idle_q      <= idle_d;
            err_seen_q  <= err_seen_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tfirst_q  <= m_tfirst_d;
            m_tdest_q   <= m_tdest_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign m_tfirst  = m_tfirst_q;
    assign m_tdest   = m_tdest_q;
    assign len_out   = len_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_eth_rx_demux.sv
// Bench for eth_rx_demux: directed frames, a frame-level reference model feeding expectation
// queues, one negedge compare process, and hand-computed literal checks on logged events.
module tb_eth_rx_demux;
    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ET  = 16'h0800;
    localparam int NCH = 4;
    localparam int MAXL = 1500;
`ifdef ETH_RX_BCAST_EN
    localparam int BC_BEATS = 4;
`else
    localparam int BC_BEATS = 0;
`endif

    logic clk = 0, reset = 1;
    logic [7:0] s_tdata = 0; logic s_tvalid = 0, s_tlast = 0, s_tready;
    logic [7:0] m_tdata; logic m_tvalid, m_tready, m_tlast, m_tfirst;
    logic [1:0] m_tdest; logic [15:0] len_out;
    logic cmd_valid; logic [3:0] cmd_code; logic err_valid; logic [2:0] err_code;

    eth_rx_demux #(.NUM_CH(NCH), .ETHERTYPE(ET), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(1023)) dut (
        .clk(clk), .reset(reset), .mac_addr(MAC),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tfirst(m_tfirst), .m_tdest(m_tdest), .len_out(len_out),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .err_valid(err_valid), .err_code(err_code));

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic f; logic l; logic [1:0] dest; } beat_t;

    int checks = 0, errors = 0, cyc = 0, stall_lo = 0;
    bit mon_en = 0, tog_mode = 0, prev_stall = 0;
    logic [7:0] prev_dat;
    logic [7:0] frm[$];
    beat_t exp_beats[$]; int exp_cmd[$]; int exp_err[$];
    int acc_cyc[$], beat_cyc[$], cmd_cyc[$], cmd_cd[$], err_cyc[$], err_cd[$];
    logic [7:0] beat_dat[$]; logic [1:0] beat_fl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input int v);
        checks++; errors++;
        $display("FAIL %s: got unexpected event %0h expected none", nm, v);
    endtask

    initial forever begin @(posedge clk); cyc++; end

    initial begin
        m_tready = 1;
        forever begin
            @(posedge clk); #1;
            m_tready = tog_mode ? !m_tready : 1'b1;
        end
    end

    // Compare process: every cycle the outputs are meaningful.
    always @(negedge clk) if (mon_en) begin
        if (s_tvalid && s_tready) acc_cyc.push_back(cyc);
        if (!m_tvalid || m_tready) chk("s_tready_free", s_tready, 1);
        if (m_tvalid && !m_tready && !s_tready) stall_lo++;
        if (prev_stall) chk("stall_hold", {m_tvalid, m_tdata}, {1'b1, prev_dat});
        prev_stall = m_tvalid && !m_tready;
        prev_dat   = m_tdata;
        if (m_tvalid && m_tready) begin
            beat_cyc.push_back(cyc); beat_dat.push_back(m_tdata); beat_fl.push_back({m_tfirst, m_tlast});
            if (exp_beats.size() == 0) unexpected("beat", m_tdata);
            else chk("beat", 32'({m_tdata, m_tfirst, m_tlast, m_tdest}), 32'(exp_beats.pop_front()));
        end
        if (cmd_valid) begin
            cmd_cyc.push_back(cyc); cmd_cd.push_back(cmd_code);
            if (exp_cmd.size() == 0) unexpected("cmd", cmd_code);
            else chk("cmd_code", cmd_code, exp_cmd.pop_front());
        end
        if (err_valid) begin
            err_cyc.push_back(cyc); err_cd.push_back(err_code);
            if (exp_err.size() == 0) unexpected("err", err_code);
            else chk("err_code", err_code, exp_err.pop_front());
        end
        if (cmd_valid && err_valid) unexpected("cmd_err_together", 1);
    end

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] hdr,
                         input logic [15:0] len, input int npay, input logic [7:0] pbase);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
        frm.push_back(et[15:8]);  frm.push_back(et[7:0]);
        frm.push_back(hdr[15:8]); frm.push_back(hdr[7:0]);
        frm.push_back(len[15:8]); frm.push_back(len[7:0]);
        for (int i = 0; i < npay; i++) frm.push_back(8'(pbase + i));
    endtask

    // Frame-level reference: decide the outcome from the whole frame's bytes.
    task automatic model();
        int n, pay, k;
        logic [47:0] d; logic [15:0] et, h, l; bit hit;
        beat_t b;
        n = frm.size();
        if (n <= 6) begin exp_err.push_back(1); return; end
        d = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        hit = (d == MAC);
`ifdef ETH_RX_BCAST_EN
        hit = hit || (d == 48'hFFFF_FFFF_FFFF);
`endif
        if (!hit) return;
        if (n <= 14) begin exp_err.push_back(1); return; end
        et = {frm[12], frm[13]};
        if (et != ET) return;
        if (n <= 16) begin exp_err.push_back(1); return; end
        h = {frm[14], frm[15]};
        if (h[15:14] == 2'b10) begin exp_cmd.push_back(int'(h[11:8])); return; end
        if (h[15:14] != 2'b01) begin exp_err.push_back(2); return; end
        if (int'(h[11:8]) >= NCH) begin exp_err.push_back(3); return; end
        if (n <= 18) begin exp_err.push_back(1); return; end
        l = {frm[16], frm[17]};
        if (l == 0 || int'(l) > MAXL) begin exp_err.push_back(4); return; end
        pay = n - 18;
        k = (pay < int'(l)) ? pay : int'(l);
        for (int i = 0; i < k; i++) begin
            b.d = frm[18+i]; b.f = (i == 0); b.l = (i == k-1); b.dest = h[9:8];
            exp_beats.push_back(b);
        end
        if (pay < int'(l)) exp_err.push_back(5);
        else if (pay > int'(l)) exp_err.push_back(6);
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); beat_cyc.delete(); beat_dat.delete(); beat_fl.delete();
        cmd_cyc.delete(); cmd_cd.delete(); err_cyc.delete(); err_cd.delete();
        stall_lo = 0;
    endtask

    task automatic send(input bit with_last);
        bit took;
        int budget;
        for (int i = 0; i < frm.size(); i++) begin
            s_tdata = frm[i]; s_tvalid = 1; s_tlast = with_last && (i == frm.size()-1);
            budget = 0;
            do begin
                @(negedge clk); took = s_tready;
                @(posedge clk); #1; budget++;
            end while (!took && budget < 200);
            if (!took) begin
                chk("s_tready_timeout", took, 1);
                break;
            end
        end
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic leftovers(input string nm);
        chk({nm, "_beats_left"}, exp_beats.size(), 0);
        chk({nm, "_cmds_left"},  exp_cmd.size(), 0);
        chk({nm, "_errs_left"},  exp_err.size(), 0);
        exp_beats.delete(); exp_cmd.delete(); exp_err.delete();
    endtask

    task automatic run(input string nm);
        clear_logs();
        model();
        send(1);
        repeat (30) @(posedge clk);
        #1;
        leftovers(nm);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m", {m_tvalid, m_tdata, m_tlast, m_tfirst, m_tdest}, 0);
        chk("rst_len", len_out, 0);
        chk("rst_strb", {cmd_valid, cmd_code, err_valid, err_code}, 0);
        chk("rst_s_tready", s_tready, 0);
        @(posedge clk); #1; reset = 0; mon_en = 1;
        repeat (2) @(posedge clk); #1;

        // Basic DATA frame, channel 2, length 4
        build(MAC, ET, 16'h4200, 16'd4, 4, 8'hA1);
        run("basic");
        chk("basic_nbeats", beat_dat.size(), 4);
        if (beat_dat.size() == 4 && acc_cyc.size() == 22) begin
            for (int i = 0; i < 4; i++) begin
                chk("basic_data", beat_dat[i], 8'hA1 + i);
                chk("basic_latency", beat_cyc[i], acc_cyc[18+i] + 1);
            end
            chk("basic_first", beat_fl[0], 2'b10);
            chk("basic_last", beat_fl[3], 2'b01);
        end
        chk("basic_dest", m_tdest, 2);
        chk("basic_len", len_out, 4);
        chk("basic_noerr", err_cd.size(), 0);

        // Same frame with downstream toggling
        tog_mode = 1;
        run("toggle");
        tog_mode = 0;
        chk("toggle_nbeats", beat_dat.size(), 4);
        chk("toggle_stall_seen", stall_lo > 0, 1);

        // COMMAND frame
        build(MAC, ET, 16'h8500, 16'd0, 4, 8'h30);
        run("cmd");
        chk("cmd_count", cmd_cd.size(), 1);
        if (cmd_cd.size() == 1 && acc_cyc.size() > 15) begin
            chk("cmd_lit_code", cmd_cd[0], 5);
            chk("cmd_cycle", cmd_cyc[0], acc_cyc[15] + 1);
        end
        chk("cmd_no_beats", beat_dat.size(), 0);

        // Long frame: declared 3, sent 5
        build(MAC, ET, 16'h4100, 16'd3, 5, 8'h50);
        run("long");
        chk("long_nbeats", beat_dat.size(), 3);
        if (beat_fl.size() == 3) chk("long_last", beat_fl[2], 2'b01);
        if (err_cd.size() == 1) chk("long_err", err_cd[0], 6); else chk("long_nerr", err_cd.size(), 1);

        // Short frame: declared 5, sent 3
        build(MAC, ET, 16'h4300, 16'd5, 3, 8'h60);
        run("short");
        chk("short_nbeats", beat_dat.size(), 3);
        if (beat_fl.size() == 3) chk("short_last", beat_fl[2], 2'b01);
        if (err_cd.size() == 1) chk("short_err", err_cd[0], 5); else chk("short_nerr", err_cd.size(), 1);

        // Bad channel, wrong EtherType, then a good frame
        build(MAC, ET, 16'h4700, 16'd4, 4, 8'h70);
        run("chbad");
        if (err_cd.size() == 1) chk("chbad_err", err_cd[0], 3); else chk("chbad_nerr", err_cd.size(), 1);
        build(MAC, 16'h86DD, 16'h4100, 16'd4, 4, 8'h80);
        run("ethertype");
        chk("et_silent", {err_cd.size(), beat_dat.size()}, 0);
        build(MAC, ET, 16'h4100, 16'd4, 4, 8'h90);
        run("after_et");
        chk("after_et_nbeats", beat_dat.size(), 4);

        // Other error classes
        build(MAC, ET, 16'h0000, 16'd4, 4, 8'h00);
        run("hdrbad");
        if (err_cd.size() == 1) chk("hdrbad_err", err_cd[0], 2); else chk("hdrbad_nerr", err_cd.size(), 1);
        build(MAC, ET, 16'h4100, 16'd0, 2, 8'h00);
        run("len0");
        build(MAC, ET, 16'h4100, 16'd1600, 2, 8'h00);
        run("lenbig");
        if (err_cd.size() == 1) chk("lenbig_err", err_cd[0], 4); else chk("lenbig_nerr", err_cd.size(), 1);
        build(MAC, ET, 16'h4100, 16'd4, 4, 8'h00);
        while (frm.size() > 10) void'(frm.pop_back());
        run("runt");
        if (err_cd.size() == 1) chk("runt_err", err_cd[0], 1); else chk("runt_nerr", err_cd.size(), 1);

        // Timeout after EtherType
        build(MAC, ET, 16'h4100, 16'd4, 0, 8'h00);
        while (frm.size() > 14) void'(frm.pop_back());
        clear_logs();
        exp_err.push_back(7);
        send(0);
        repeat (1040) @(posedge clk);
        #1;
        leftovers("timeout");
        if (err_cd.size() == 1 && acc_cyc.size() == 14) begin
            chk("timeout_err", err_cd[0], 7);
            chk("timeout_cycle", err_cyc[0], acc_cyc[13] + 1024);
        end else chk("timeout_nerr", err_cd.size(), 1);
        build(MAC, ET, 16'h4000, 16'd2, 2, 8'hC0);
        run("after_tmo");
        chk("after_tmo_nbeats", beat_dat.size(), 2);

        // Broadcast destination
        build(48'hFFFF_FFFF_FFFF, ET, 16'h4100, 16'd4, 4, 8'hD0);
        run("bcast");
        chk("bcast_beats", beat_dat.size(), BC_BEATS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
